// File: rtl/vec_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_exec_pkg
// Description : Shared types for the vector execute stage: ALU opcodes, FSM
//               states and the beat-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_exec_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLL  = 3'd5,
        OP_SRL  = 3'd6,
        OP_RSV7 = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } exec_state_t;

    function automatic int calc_beats(input int items, input int lanes);
        return (items + lanes - 1) / lanes;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_exec_lane_alu.sv
`default_nettype none
// ============================================================================
// Module      : lane_alu
// Description : Combinational single-element ALU. With VEC_EXEC_SAT_ARITH_EN
//               defined, ADD/SUB saturate instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_alu
    import vec_exec_pkg::*;
#(
    parameter int L = 8
) (
    input  logic [L-1:0] i_a,
    input  logic [L-1:0] i_b,
    input  alu_op_t      i_op,
    output logic [L-1:0] o_result
);

    localparam int c_sh_w = $clog2(L);

    logic [c_sh_w-1:0] w_sh;
    assign w_sh = i_b[c_sh_w-1:0];

`ifdef VEC_EXEC_SAT_ARITH_EN
    // Extra MSB carries the overflow / borrow that selects the clamp value.
    logic [L:0] w_sum;
    logic [L:0] w_diff;
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
`else
    logic [L-1:0] w_sum;
    logic [L-1:0] w_diff;
    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
`endif

    always_comb begin
        o_result = '0;
        case (i_op)
`ifdef VEC_EXEC_SAT_ARITH_EN
            OP_ADD:  o_result = w_sum[L]  ? '1 : w_sum[L-1:0];
            OP_SUB:  o_result = w_diff[L] ? '0 : w_diff[L-1:0];
`else
            OP_ADD:  o_result = w_sum;
            OP_SUB:  o_result = w_diff;
`endif
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLL:  o_result = i_a << w_sh;
            OP_SRL:  o_result = i_a >> w_sh;
            OP_RSV7: o_result = '0;
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vec_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : vec_exec_stage
// Description : Lane-serial vector/scalar execute stage feeding the memory
//               stage through a valid/ack handshake. Optional saturating
//               ADD/SUB via VEC_EXEC_SAT_ARITH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_exec_stage
    import vec_exec_pkg::*;
#(
    parameter int I     = 20,
    parameter int L     = 8,
    parameter int LANES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           op_type,
    input  logic [2:0]     alu_op,
    input  logic           bcast_b,
    input  logic [I*L-1:0] vec_a,
    input  logic [I*L-1:0] vec_b,
    input  logic [L-1:0]   sca_a,
    input  logic [L-1:0]   sca_b,
    output logic           ready,
    output logic           busy,
    output logic           result_valid,
    input  logic           result_ack,
    output logic [I*L-1:0] aluResultV,
    output logic [L-1:0]   aluResultS
);

    localparam int c_beats  = calc_beats(I, LANES);
    localparam int c_beat_w = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_idx_w  = $clog2(c_beats * LANES) + 1;

    exec_state_t           r_state;
    logic [c_beat_w-1:0]   r_beat;
    logic [I*L-1:0]        r_vec_a;
    logic [I*L-1:0]        r_vec_b;
    logic [L-1:0]          r_sca_a;
    logic [L-1:0]          r_sca_b;
    logic                  r_op_type;
    alu_op_t               r_alu_op;
    logic                  r_bcast;
    logic [I*L-1:0]        r_res_v;
    logic [L-1:0]          r_res_s;
    logic                  r_valid;

    logic [L-1:0]          w_a   [LANES];
    logic [L-1:0]          w_b   [LANES];
    logic [L-1:0]          w_res [LANES];
    logic [c_idx_w-1:0]    w_idx [LANES];
    logic [c_idx_w-1:0]    w_sel [LANES];
    logic [LANES-1:0]      w_in_range;
    logic                  w_accept;
    logic                  w_last;

    assign ready        = (r_state == ST_IDLE) | ((r_state == ST_DONE) & result_ack);
    assign busy         = (r_state == ST_RUN);
    assign result_valid = r_valid;
    assign aluResultV   = r_res_v;
    assign aluResultS   = r_res_s;
    assign w_accept     = start & ready;
    assign w_last       = (r_beat == c_beat_w'(c_beats - 1));

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            // Lanes past the end of the vector on a partial last beat are
            // steered to element 0 and their results discarded.
            assign w_idx[j]      = c_idx_w'(r_beat) * c_idx_w'(LANES) + c_idx_w'(j);
            assign w_in_range[j] = (w_idx[j] < c_idx_w'(I));
            assign w_sel[j]      = w_in_range[j] ? w_idx[j] : '0;
            assign w_a[j]        = r_op_type ? r_vec_a[w_sel[j]*L +: L] : r_sca_a;
            assign w_b[j]        = (r_op_type && !r_bcast) ? r_vec_b[w_sel[j]*L +: L] : r_sca_b;

            lane_alu #(.L(L)) u_lane_alu (
                .i_a      (w_a[j]),
                .i_b      (w_b[j]),
                .i_op     (r_alu_op),
                .o_result (w_res[j])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_vec_a   <= '0;
            r_vec_b   <= '0;
            r_sca_a   <= '0;
            r_sca_b   <= '0;
            r_op_type <= 1'b0;
            r_alu_op  <= OP_ADD;
            r_bcast   <= 1'b0;
            r_res_v   <= '0;
            r_res_s   <= '0;
            r_valid   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_vec_a   <= vec_a;
                r_vec_b   <= vec_b;
                r_sca_a   <= sca_a;
                r_sca_b   <= sca_b;
                r_op_type <= op_type;
                r_alu_op  <= alu_op_t'(alu_op);
                r_bcast   <= bcast_b;
                r_beat    <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!r_op_type) begin
                        r_res_s <= w_res[0];
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        for (int j = 0; j < LANES; j++) begin
                            if (w_in_range[j]) r_res_v[w_sel[j]*L +: L] <= w_res[j];
                        end
                        if (w_last) begin
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_beat <= r_beat + c_beat_w'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (result_ack) begin
                        r_valid <= 1'b0;
                        r_state <= start ? ST_RUN : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
